reg_wr_arb: RTL

REG_WR_ARB -- requirements
Module: reg_wr_arb

---
 rtl/reg_wr_arb_pkg.sv | 9 +
 rtl/reg_wr_arb_en_flop.sv | 19 +
 rtl/reg_wr_arb_rr_pick.sv | 28 ++
 rtl/reg_wr_arb.sv | 115 +++++++++++
 4 files changed

// File: rtl/reg_wr_arb_pkg.sv
// Shared types and constants for the reg_wr_arb write arbiter.
package reg_wr_arb_pkg;
   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;
endpackage

// File: rtl/reg_wr_arb_en_flop.sv
// Enable flop primitive: asynchronous active-high reset to zero, load on en.
module en_flop #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q_q <= '0;
      else if (en) q_q <= d;
   end

   assign q = q_q;
endmodule

// File: rtl/reg_wr_arb_rr_pick.sv
// Combinational round-robin picker: search starts one past last_ptr and wraps.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vld,
   input  logic [IW-1:0] last_ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   int   j;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last_ptr) + k) % N;
         if (!found && vld[j]) begin
            gnt[j] = 1'b1;
            idx    = IW'(j);
            found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/reg_wr_arb.sv
// Round-robin arbiter for writes into one shared register, with post-write lockout.
// Optional parity output q_par is enabled by defining REG_WR_ARB_PARITY_EN.
module reg_wr_arb
   import reg_wr_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int W        = 32,
   parameter int HOLD_CYC = 2
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [N-1:0]          req_vld,
   input  logic [N-1:0][W-1:0]   req_data,
   output logic [N-1:0]          req_rdy,
   output logic [W-1:0]          q,
   output logic                  q_vld,
   output logic                  upd,
   output logic [$clog2(N)-1:0]  upd_id,
   output logic                  busy
`ifdef REG_WR_ARB_PARITY_EN
   ,output logic                 q_par
`endif
);
   localparam int IW = $clog2(N);
   localparam logic [CNT_W-1:0] HOLD_INIT = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    upd_id_q, upd_id_d;
   logic             upd_q, upd_d;
   logic             q_vld_q, q_vld_d;
   logic [N-1:0]     pick_gnt;
   logic [IW-1:0]    pick_idx;
   logic             accept;
   logic [W-1:0]     wr_data;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .vld      (req_vld),
      .last_ptr (last_q),
      .gnt      (pick_gnt),
      .idx      (pick_idx)
   );

   always_comb begin
      req_rdy  = (state_q == IDLE && !arst) ? pick_gnt : '0;
      accept   = |(req_vld & req_rdy);
      wr_data  = req_data[pick_idx];
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      upd_id_d = upd_id_q;
      upd_d    = accept;
      q_vld_d  = q_vld_q | accept;
      case (state_q)
         IDLE: begin
            if (accept) begin
               last_d   = pick_idx;
               upd_id_d = pick_idx;
               // With zero lockout the arbiter stays in IDLE for back-to-back writes
               if (HOLD_CYC > 0) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_INIT;
               end
            end
         end
         HOLD: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= IW'(N - 1);
         upd_id_q <= '0;
         upd_q    <= 1'b0;
         q_vld_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         upd_id_q <= upd_id_d;
         upd_q    <= upd_d;
         q_vld_q  <= q_vld_d;
      end
   end

   en_flop #(.W(W)) u_q (
      .clk (clk),
      .rst (arst),
      .en  (accept),
      .d   (wr_data),
      .q   (q)
   );

`ifdef REG_WR_ARB_PARITY_EN
   en_flop #(.W(1)) u_par (
      .clk (clk),
      .rst (arst),
      .en  (accept),
      .d   (^wr_data),
      .q   (q_par)
   );
`endif

   assign q_vld  = q_vld_q;
   assign upd    = upd_q;
   assign upd_id = upd_id_q;
   assign busy   = (state_q == HOLD);
endmodule
